// File: rtl/stopwatch_seq_if.sv
// stopwatch_seq_if: command-ROM fetch interface.
//   addr    - ROM address of the current fetch (initiator -> ROM)
//   valid   - one-cycle fetch strobe; ROM latches addr on this edge
//   rd_data - registered ROM word, valid the cycle after valid was high
// Modports: master (the sequencer), slave (the ROM).
interface stopwatch_seq_if #(
    parameter int unsigned DATA_SIZE = 3,
    parameter int unsigned ADDR_SIZE = 4
);
    logic [ADDR_SIZE-1:0] addr;
    logic                 valid;
    logic [DATA_SIZE-1:0] rd_data;

    modport master (
        output addr,
        output valid,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  valid,
        output rd_data
    );
endinterface

// File: rtl/stopwatch_seq.sv
// stopwatch_seq: periodically fetches stopwatch commands from a command ROM and
// runs a min:sec stopwatch from them.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset (shared with the ROM)
//   rom   - master side of the ROM fetch interface (addr, valid, rd_data)
//   state - 00 idle, 01 run, 10 pause, 11 stop
//   sec   - seconds 0..59
//   min   - minutes 0..59
module stopwatch_seq #(
    parameter int unsigned DATA_SIZE   = 3,
    parameter int unsigned ADDR_SIZE   = 4,
    parameter int unsigned STEP_CYCLES = 8,
    parameter int unsigned TICK_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    stopwatch_seq_if.master        rom,
    output logic [1:0]             state,
    output logic [5:0]             sec,
    output logic [5:0]             min
);

    localparam int unsigned StepW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned TickW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);

    localparam logic [DATA_SIZE-1:0] CmdIdle  = DATA_SIZE'(0);
    localparam logic [DATA_SIZE-1:0] CmdStart = DATA_SIZE'(1);
    localparam logic [DATA_SIZE-1:0] CmdPause = DATA_SIZE'(2);
    localparam logic [DATA_SIZE-1:0] CmdStop  = DATA_SIZE'(3);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StStop  = 2'b11
    } state_e;

    state_e               state_q, state_d;
    logic [StepW-1:0]     step_cnt_q, step_cnt_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic                 cmd_pending_q, cmd_pending_d;
    logic [5:0]           sec_q, sec_d;
    logic [5:0]           min_q, min_d;
    logic                 fetch;
    logic                 count_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            step_cnt_q    <= '0;
            tick_cnt_q    <= '0;
            addr_q        <= '0;
            cmd_pending_q <= 1'b0;
            sec_q         <= '0;
            min_q         <= '0;
        end else begin
            state_q       <= state_d;
            step_cnt_q    <= step_cnt_d;
            tick_cnt_q    <= tick_cnt_d;
            addr_q        <= addr_d;
            cmd_pending_q <= cmd_pending_d;
            sec_q         <= sec_d;
            min_q         <= min_d;
        end
    end

    always_comb begin
        fetch         = (step_cnt_q == StepLast);
        step_cnt_d    = fetch ? '0 : step_cnt_q + StepW'(1);
        // ROM samples the old addr on the strobe edge; its word arrives next cycle.
        addr_d        = fetch ? addr_q + ADDR_SIZE'(1) : addr_q;
        // STEP_CYCLES >= 2 guarantees a pending command never overlaps a new fetch.
        cmd_pending_d = fetch;

        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        sec_d      = sec_q;
        min_d      = min_q;
        count_en   = (state_q == StRun);

        if (cmd_pending_q) begin
            case (rom.rd_data)
                CmdIdle: begin
                    state_d    = StIdle;
                    tick_cnt_d = '0;
                    sec_d      = '0;
                    min_d      = '0;
                    count_en   = 1'b0;
                end
                CmdStart: begin
                    if (state_q == StStop) begin
                        tick_cnt_d = '0;
                        sec_d      = '0;
                        min_d      = '0;
                    end
                    // Start while running is a no-op, so that edge still counts.
                    state_d = StRun;
                end
                CmdPause: begin
                    if (state_q == StRun) begin
                        state_d  = StPause;
                        count_en = 1'b0;
                    end
                end
                CmdStop: begin
                    if (state_q == StRun || state_q == StPause) begin
                        state_d    = StStop;
                        tick_cnt_d = '0;
                        count_en   = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end

        if (count_en) begin
            if (tick_cnt_q == TickLast) begin
                tick_cnt_d = '0;
                if (sec_q == 6'd59) begin
                    sec_d = '0;
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TickW'(1);
            end
        end
    end

    assign rom.addr  = addr_q;
    assign rom.valid = fetch;
    assign state     = state_q;
    assign sec       = sec_q;
    assign min       = min_q;

endmodule
